// File: rtl/risc0_seg_pkg.sv
// Shared record format, tag codes and serializer state for the segment collector.
package risc0_seg_pkg;

  localparam int REC_W = 72;

  localparam logic [7:0] TAG_SEG  = 8'hA5;
  localparam logic [7:0] TAG_DONE = 8'hD0;
  localparam logic [7:0] TAG_ERR  = 8'hDE;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] seg;
    logic [31:0] cyc;
  } seg_rec_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_t;

endpackage

// File: rtl/seg_fifo.sv
// Synchronous record FIFO with a wrap bit on each pointer to tell full from empty.
module seg_fifo #(
  parameter int DATA_W = 72,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A write into a full FIFO is allowed only when the head leaves in the same cycle.
  assign wr_en = push && !clear && (!full || pop);
  assign rd_en = pop && !clear && !empty;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/segment_collector.sv
// Captures executor segment/done events as 72-bit records and streams them out
// as 9-byte little-endian packets over a valid/ready byte link.
module segment_collector
  import risc0_seg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    segment_ready,
  input  logic [31:0]             segment_data,
  input  logic [63:0]             total_cycles,
  input  logic                    execution_done,
  input  logic                    execution_error,
  output logic                    segment_ack,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    busy
);

  function automatic logic [7:0] rec_byte(input seg_rec_t r, input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = r.tag;
      4'd1:    b = r.seg[7:0];
      4'd2:    b = r.seg[15:8];
      4'd3:    b = r.seg[23:16];
      4'd4:    b = r.seg[31:24];
      4'd5:    b = r.cyc[7:0];
      4'd6:    b = r.cyc[15:8];
      4'd7:    b = r.cyc[23:16];
      4'd8:    b = r.cyc[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic             ack_q;
  logic             done_q;
  logic             done_pending;
  logic             err_q;
  logic             capture;
  logic             done_rise;
  logic             done_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  seg_rec_t         push_rec;
  seg_rec_t         head_rec;
  logic [REC_W-1:0] head_bits;
  seg_rec_t         rec;
  ser_state_t       state;
  ser_state_t       state_nx;
  logic [3:0]       idx;
  logic [3:0]       idx_nx;
  logic             unused_cyc_hi;

  assign unused_cyc_hi = ^total_cycles[63:32];

  // Capture side: segment wins over a pending done record in the same cycle.
  assign capture   = segment_ready && !fifo_full && !ack_q && !clear;
  assign done_rise = execution_done && !done_q;
  assign done_push = done_pending && !capture && !fifo_full && !clear;

  always_comb begin
    push_rec.tag = capture ? TAG_SEG : (err_q ? TAG_ERR : TAG_DONE);
    push_rec.seg = capture ? segment_data : 32'h0;
    push_rec.cyc = total_cycles[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      done_pending <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ack_q  <= capture;
      done_q <= execution_done;
      if (clear) begin
        done_pending <= 1'b0;
      end else if (done_rise) begin
        done_pending <= 1'b1;
        err_q        <= execution_error;
      end else if (done_push) begin
        done_pending <= 1'b0;
      end
    end
  end

  seg_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (capture || done_push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign head_rec = head_bits;

  // Serializer: the last byte's handshake reloads directly from the FIFO head.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    pop      = 1'b0;
    if (clear) begin
      state_nx = S_IDLE;
      idx_nx   = 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = S_SEND;
            idx_nx   = 4'd0;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (idx == 4'd8) begin
              idx_nx = 4'd0;
              if (!fifo_empty) pop = 1'b1;
              else             state_nx = S_IDLE;
            end else begin
              idx_nx = idx + 4'd1;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) rec <= head_rec;
  end

  assign segment_ack = ack_q;
  assign out_valid   = (state == S_SEND);
  assign out_data    = out_valid ? rec_byte(rec, idx) : 8'h00;
  assign busy        = !fifo_empty || (state != S_IDLE) || done_pending;

endmodule

// File: tb/tb_segment_collector.sv
// Scoreboard bench for segment_collector: expected bytes are queued as stimulus is driven.
module tb_segment_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        segment_ready = 1'b0;
  logic [31:0] segment_data = '0;
  logic [63:0] total_cycles = '0;
  logic        execution_done = 1'b0;
  logic        execution_error = 1'b0;
  logic        out_ready = 1'b0;
  logic        segment_ack;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [7:0] exp_q[$];
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = '0;

  segment_collector #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .segment_ready   (segment_ready),
    .segment_data    (segment_data),
    .total_cycles    (total_cycles),
    .execution_done  (execution_done),
    .execution_error (execution_error),
    .segment_ack     (segment_ack),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .fifo_level      (fifo_level),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_rec(input logic [7:0] tag, input logic [31:0] seg, input logic [31:0] cyc);
    exp_q.push_back(tag);
    for (int i = 0; i < 4; i++) exp_q.push_back(seg[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(cyc[8*i +: 8]);
  endtask

  task automatic seg_req(input logic [31:0] d, input logic [63:0] c, input bit with_done);
    bit got;
    got = 1'b0;
    @(posedge clk) #1;
    segment_ready = 1'b1;
    segment_data  = d;
    total_cycles  = c;
    if (with_done) begin
      execution_done  = 1'b1;
      execution_error = 1'b0;
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk) #1;
      if (segment_ack) begin
        got = 1'b1;
        break;
      end
    end
    segment_ready = 1'b0;
    check("ack_seen", got, 1);
    push_rec(8'hA5, d, c[31:0]);
    if (with_done) push_rec(8'hD0, 32'h0, c[31:0]);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk) #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Byte monitor: pops the scoreboard on each handshake, checks stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && out_valid) check("stall_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", out_data, 64'h100);
        else check("byte", out_data, exp_q.pop_front());
        hs_count++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    bit acc;
    bit got;
    int base;

    #12;
    check("rst_ack", segment_ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    @(posedge clk) #1;
    rst_n = 1'b1;

    // Single segment with latency and one-cycle ack
    out_ready = 1'b1;
    seg_req(32'h0000_0003, 64'h1_0000_0010, 1'b0);
    @(posedge clk) #1;
    check("single_ack_pulse", segment_ack, 0);
    check("single_latency_valid", out_valid, 1);
    drain(40);
    check("single_busy_after", busy, 0);

    // Backpressure: one record sits in the serializer, four fill the FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) seg_req(32'h100 + i, 64'h2000 + i, 1'b0);
    check("bp_level_full", fifo_level, 4);
    @(posedge clk) #1;
    segment_ready = 1'b1;
    segment_data  = 32'h1FF;
    total_cycles  = 64'h2FFF;
    acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1;
      acc |= segment_ack;
    end
    check("bp_ack_withheld", acc, 0);
    check("bp_level_held", fifo_level, 4);
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk) #1;
      if (segment_ack) begin
        got = 1'b1;
        break;
      end
    end
    segment_ready = 1'b0;
    check("bp_late_ack", got, 1);
    push_rec(8'hA5, 32'h1FF, 32'h2FFF);
    drain(120);

    // Done with error on an empty FIFO
    @(posedge clk) #1;
    total_cycles    = 64'hDEAD_0000_CAFE_F00D;
    execution_done  = 1'b1;
    execution_error = 1'b1;
    push_rec(8'hDE, 32'h0, 32'hCAFE_F00D);
    drain(40);
    check("done_busy_after", busy, 0);
    execution_done  = 1'b0;
    execution_error = 1'b0;

    // Collision at level 3: segment first, done record after the next pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) seg_req(32'h300 + i, 64'h4000, 1'b0);
    check("col_level3", fifo_level, 3);
    seg_req(32'h3AA, 64'h4000, 1'b1);
    check("col_level4", fifo_level, 4);
    repeat (3) @(posedge clk);
    #1;
    check("col_done_waits", fifo_level, 4);
    check("col_busy", busy, 1);
    out_ready = 1'b1;
    drain(120);
    check("col_busy_after", busy, 0);
    execution_done = 1'b0;

    // Random stalls across three records
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) seg_req($urandom, {32'h0, $urandom}, 1'b0);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk) #1;
      out_ready = 1'(($urandom_range(0, 1)));
      if (exp_q.size() == 0) break;
    end
    out_ready = 1'b1;
    drain(40);

    // Clear flushes queued records
    out_ready = 1'b0;
    seg_req(32'h55, 64'h66, 1'b0);
    seg_req(32'h77, 64'h88, 1'b0);
    @(posedge clk) #1;
    clear = 1'b1;
    @(posedge clk) #1;
    clear = 1'b0;
    exp_q.delete();
    check("clr_level", fifo_level, 0);
    check("clr_valid", out_valid, 0);
    check("clr_busy", busy, 0);

    // Reset in the middle of a record
    out_ready = 1'b1;
    base = hs_count;
    seg_req(32'hABCD_1234, 64'h9999, 1'b0);
    for (int i = 0; i < 40 && hs_count < base + 5; i++) @(posedge clk);
    check("rst_mid_reached", hs_count >= base + 5, 1);
    @(posedge clk) #1;
    rst_n = 1'b0;
    #1;
    check("rstm_valid", out_valid, 0);
    check("rstm_data", out_data, 0);
    check("rstm_ack", segment_ack, 0);
    check("rstm_level", fifo_level, 0);
    check("rstm_busy", busy, 0);
    exp_q.delete();
    @(posedge clk) #1;
    rst_n = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      acc |= out_valid;
    end
    check("rstm_no_partial", acc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
